// File: rtl/ddr_req_arbiter_pkg.sv
// rtl/ddr_req_arbiter_pkg.sv - shared types and defaults for the DDR request arbiter
// Contents: FSM state enum, default port/address widths, acknowledge timeout,
// and a wrap-around index helper shared by the arbiter and its priority picker.
package ddr_req_arbiter_pkg;

  localparam int DEF_NUM_PORTS = 4;
  localparam int DEF_ROW_W     = 13;
  localparam int DEF_COL_W     = 10;
  localparam int DEF_BA_W      = 2;

  localparam int ACK_TIMEOUT   = 255;
  localparam int ACK_CNT_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RELEASE   = 3'd4
  } arb_state_t;

  // (base + off) mod n, for base < n and off < n.
  function automatic int wrap_idx(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/ddr_req_arbiter_pick.sv
// rtl/ddr_req_arbiter_pick.sv - combinational round-robin priority picker
// Ports:
//   req    in  N   request vector
//   ptr    in  IW  search start index (highest priority)
//   onehot out N   one-hot winner
//   idx    out IW  winner index
//   valid  out 1   at least one request present
module rr_priority_pick
  import ddr_req_arbiter_pkg::*;
#(
  parameter int N = DEF_NUM_PORTS,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] cand;

  // Scan from the candidate furthest from ptr back toward ptr so the nearest
  // asserted request is the last one written and therefore wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = IW'(wrap_idx(int'(ptr), i, N));
      if (req[cand]) begin
        valid        = 1'b1;
        idx          = cand;
        onehot       = '0;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_req_arbiter.sv
// rtl/ddr_req_arbiter.sv - round-robin front end sharing one DDR controller command port
// Ports:
//   clk, rst                          clock, async active-high reset
//   req, req_wr                       per-port request level and write flag
//   req_row, req_col, req_ba          packed per-port command addresses
//   gnt, done, err                    one-hot grant, one-hot completion pulse, timeout pulse
//   init_done, ctrl_busy              controller status
//   addr_strobe, rd_wr_req            active-low command strobe and direction
//   sys_addr_row, sys_addr_col, sys_ba command address to the controller
module ddr_req_arbiter
  import ddr_req_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int ROW_W     = DEF_ROW_W,
  parameter int COL_W     = DEF_COL_W,
  parameter int BA_W      = DEF_BA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_PORTS-1:0]      req,
  input  logic [NUM_PORTS-1:0]      req_wr,
  input  logic [NUM_PORTS*ROW_W-1:0] req_row,
  input  logic [NUM_PORTS*COL_W-1:0] req_col,
  input  logic [NUM_PORTS*BA_W-1:0]  req_ba,
  output logic [NUM_PORTS-1:0]      gnt,
  output logic [NUM_PORTS-1:0]      done,
  output logic                      err,
  input  logic                      init_done,
  input  logic                      ctrl_busy,
  output logic                      addr_strobe,
  output logic                      rd_wr_req,
  output logic [ROW_W-1:0]          sys_addr_row,
  output logic [COL_W-1:0]          sys_addr_col,
  output logic [BA_W-1:0]           sys_ba
);

  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  arb_state_t           state;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        port;
  logic [ACK_CNT_W-1:0] ack_cnt;

  logic [NUM_PORTS-1:0] win_onehot;
  logic [IW-1:0]        win_idx;
  logic                 win_valid;

  rr_priority_pick #(.N(NUM_PORTS)) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .onehot (win_onehot),
    .idx    (win_idx),
    .valid  (win_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      port         <= '0;
      ack_cnt      <= '0;
      gnt          <= '0;
      done         <= '0;
      err          <= 1'b0;
      addr_strobe  <= 1'b1;
      rd_wr_req    <= 1'b0;
      sys_addr_row <= '0;
      sys_addr_col <= '0;
      sys_ba       <= '0;
    end else begin
      addr_strobe <= 1'b1;
      done        <= '0;
      err         <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A controller refresh shows as ctrl_busy here and simply holds off arbitration.
          if (init_done && !ctrl_busy && win_valid) begin
            port         <= win_idx;
            gnt          <= win_onehot;
            rd_wr_req    <= req_wr[win_idx];
            sys_addr_row <= req_row[win_idx*ROW_W +: ROW_W];
            sys_addr_col <= req_col[win_idx*COL_W +: COL_W];
            sys_ba       <= req_ba[win_idx*BA_W +: BA_W];
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          addr_strobe <= 1'b0;
          ack_cnt     <= '0;
          state       <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (ctrl_busy) begin
            state <= ST_WAIT_DONE;
          end else if (ack_cnt == ACK_CNT_W'(ACK_TIMEOUT)) begin
            // done/err are registered on entry so they are visible during RELEASE.
            done  <= gnt;
            err   <= 1'b1;
            state <= ST_RELEASE;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!ctrl_busy) begin
            done  <= gnt;
            state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          gnt          <= '0;
          rd_wr_req    <= 1'b0;
          sys_addr_row <= '0;
          sys_addr_col <= '0;
          sys_ba       <= '0;
          rr_ptr       <= IW'(wrap_idx(int'(port), 1, NUM_PORTS));
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// tb/tb_ddr_req_arbiter.sv - self-checking bench for ddr_req_arbiter
module tb_ddr_req_arbiter;

  localparam int NP = 4;
  localparam int RW = 13;
  localparam int CW = 10;
  localparam int BW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     req;
  logic [NP-1:0]     req_wr;
  logic [NP*RW-1:0]  req_row;
  logic [NP*CW-1:0]  req_col;
  logic [NP*BW-1:0]  req_ba;
  logic [NP-1:0]     gnt;
  logic [NP-1:0]     done;
  logic              err;
  logic              init_done;
  logic              ctrl_busy;
  logic              addr_strobe;
  logic              rd_wr_req;
  logic [RW-1:0]     sys_addr_row;
  logic [CW-1:0]     sys_addr_col;
  logic [BW-1:0]     sys_ba;

  always #5 clk = ~clk;

  ddr_req_arbiter #(.NUM_PORTS(NP), .ROW_W(RW), .COL_W(CW), .BA_W(BW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_wr       (req_wr),
    .req_row      (req_row),
    .req_col      (req_col),
    .req_ba       (req_ba),
    .gnt          (gnt),
    .done         (done),
    .err          (err),
    .init_done    (init_done),
    .ctrl_busy    (ctrl_busy),
    .addr_strobe  (addr_strobe),
    .rd_wr_req    (rd_wr_req),
    .sys_addr_row (sys_addr_row),
    .sys_addr_col (sys_addr_col),
    .sys_ba       (sys_ba)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Per-port request contents kept by the bench.
  logic [RW-1:0] a_row [NP];
  logic [CW-1:0] a_col [NP];
  logic [BW-1:0] a_ba  [NP];
  logic          a_wr  [NP];
  int            m_ptr;

  // Controller model: busy rises ack_delay negedges after the strobe, lasts busy_len.
  int ack_delay = 2;
  int busy_len  = 3;
  bit no_ack    = 1'b0;
  int c_phase   = 0;
  int c_left    = 0;

  always @(negedge clk) begin
    if (rst) begin
      ctrl_busy = 1'b0;
      c_phase   = 0;
    end else if (c_phase == 0) begin
      if (!addr_strobe && !no_ack) begin
        c_left  = ack_delay;
        c_phase = 1;
      end
    end else if (c_phase == 1) begin
      if (c_left <= 1) begin
        ctrl_busy = 1'b1;
        c_left    = busy_len;
        c_phase   = 2;
      end else c_left--;
    end else begin
      if (c_left <= 1) begin
        ctrl_busy = 1'b0;
        c_phase   = 0;
      end else c_left--;
    end
  end

  // Results of the most recent command observed by run_cmd.
  logic [NP-1:0] r_done, r_gnt;
  logic          r_err, r_wr;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [BW-1:0] r_ba;
  int            r_nstb, r_gcyc, r_scyc, r_dcyc;
  int            exp_p;
  int            extra;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bus();
    for (int p = 0; p < NP; p++) begin
      req_wr[p]            = a_wr[p];
      req_row[p*RW +: RW]  = a_row[p];
      req_col[p*CW +: CW]  = a_col[p];
      req_ba[p*BW +: BW]   = a_ba[p];
    end
  endtask

  task automatic new_addr(input int p);
    a_row[p] = RW'($urandom);
    a_col[p] = CW'($urandom);
    a_ba[p]  = BW'($urandom);
    a_wr[p]  = 1'($urandom);
  endtask

  // Round-robin rule: first asserted request at or after ptr, wrapping upward.
  function automatic int model_pick(input logic [NP-1:0] r, input int ptr);
    for (int k = 0; k < NP; k++)
      if (r[(ptr + k) % NP]) return (ptr + k) % NP;
    return -1;
  endfunction

  task automatic run_cmd(input int budget, input logic [NP-1:0] drop_mask, input bit drop_init);
    r_nstb = 0; r_gcyc = -1; r_scyc = -1; r_dcyc = -1;
    r_done = '0; r_err = 1'b0; r_gnt = '0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (r_gcyc < 0 && gnt != '0) r_gcyc = i;
      if (!addr_strobe) begin
        r_nstb++;
        r_scyc = i;
        r_gnt  = gnt;
        r_wr   = rd_wr_req;
        r_row  = sys_addr_row;
        r_col  = sys_addr_col;
        r_ba   = sys_ba;
      end
      if (ctrl_busy && drop_mask != '0) begin
        req = req & ~drop_mask;
        if (drop_init) init_done = 1'b0;
      end
      if (done != '0) begin
        r_done = done;
        r_err  = err;
        r_dcyc = i;
        break;
      end
    end
    check("cmd_completes", 32'(r_dcyc > 0), 32'd1);
  endtask

  task automatic verify_cmd(input string tag, input int p, input bit exp_err);
    check({tag, "_done"},   32'(r_done), 32'(1 << p));
    check({tag, "_nstb"},   r_nstb, 1);
    check({tag, "_gnt"},    32'(r_gnt), 32'(1 << p));
    check({tag, "_rdwr"},   32'(r_wr), 32'(a_wr[p]));
    check({tag, "_row"},    32'(r_row), 32'(a_row[p]));
    check({tag, "_col"},    32'(r_col), 32'(a_col[p]));
    check({tag, "_ba"},     32'(r_ba), 32'(a_ba[p]));
    check({tag, "_err"},    32'(r_err), 32'(exp_err));
    m_ptr = (p + 1) % NP;
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, "_gnt"},    32'(gnt), 0);
    check({tag, "_strobe"}, 32'(addr_strobe), 1);
    check({tag, "_row"},    32'(sys_addr_row), 0);
    check({tag, "_done"},   32'(done), 0);
  endtask

  initial begin
    rst = 1'b1; init_done = 1'b0; req = '0;
    req_wr = '0; req_row = '0; req_col = '0; req_ba = '0;
    for (int p = 0; p < NP; p++) new_addr(p);
    drive_bus();
    req = '1;

    // Reset with every port requesting and init_done low.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_strobe", 32'(addr_strobe), 1);
      check("rst_gnt", 32'(gnt), 0);
    end
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_rdwr", 32'(rd_wr_req), 0);
    check("rst_addr", 32'({sys_addr_row, sys_addr_col, sys_ba}), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("noinit_gnt", 32'(gnt), 0);
      check("noinit_strobe", 32'(addr_strobe), 1);
    end

    // Fairness: all ports request continuously, random addresses and controller timing.
    init_done = 1'b1;
    m_ptr = 0;
    for (int k = 0; k < 8; k++) begin
      ack_delay = $urandom_range(1, 3);
      busy_len  = $urandom_range(1, 6);
      exp_p = model_pick(req, m_ptr);
      run_cmd(100, '0, 1'b0);
      if (k == 0) check("first_grant_port0", 32'(r_done), 32'd1);
      verify_cmd("fair", exp_p, 1'b0);
      check("fair_gnt_lat", r_gcyc, 1);
      check("fair_stb_lat", r_scyc, 2);
      new_addr(exp_p);
      if (k == 7) req = '0;
      drive_bus();
      idle_check("fair_idle");
    end

    // Single write on port 2.
    a_row[2] = 13'h10F0; a_col[2] = 10'h3E0; a_ba[2] = 2'd3; a_wr[2] = 1'b1;
    drive_bus();
    ack_delay = 2; busy_len = 10;
    req = 4'b0100;
    exp_p = model_pick(req, m_ptr);
    run_cmd(100, '0, 1'b0);
    verify_cmd("wr", exp_p, 1'b0);
    check("wr_row_abs", 32'(r_row), 32'h10F0);
    check("wr_gnt_lat", r_gcyc, 1);
    check("wr_stb_lat", r_scyc, 2);
    req = '0;
    idle_check("wr_idle");
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done != '0 || err) extra++;
    end
    check("wr_done_once", extra, 0);

    // Port 1 drops req (and init_done falls) while the controller is busy.
    new_addr(1);
    drive_bus();
    ack_delay = $urandom_range(1, 3); busy_len = $urandom_range(3, 8);
    req = 4'b0010;
    exp_p = model_pick(req, m_ptr);
    run_cmd(100, 4'b0010, 1'b1);
    verify_cmd("drop", exp_p, 1'b0);
    idle_check("drop_idle");

    // With init_done low a new request waits.
    new_addr(0);
    drive_bus();
    req = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("init_low_gnt", 32'(gnt), 0);
    end
    init_done = 1'b1;
    exp_p = model_pick(req, m_ptr);
    run_cmd(100, '0, 1'b0);
    verify_cmd("reinit", exp_p, 1'b0);
    check("reinit_gnt_lat", r_gcyc, 1);
    req = '0;
    idle_check("reinit_idle");

    // Acknowledge timeout, then the next waiting port is served.
    new_addr(0); new_addr(3);
    drive_bus();
    no_ack = 1'b1;
    req = 4'b1001;
    exp_p = model_pick(req, m_ptr);
    run_cmd(400, '0, 1'b0);
    verify_cmd("to", exp_p, 1'b1);
    check("to_latency", r_dcyc - r_scyc, 256);
    no_ack = 1'b0;
    req = req & ~NP'(1 << exp_p);
    idle_check("to_idle");
    ack_delay = 1; busy_len = 2;
    exp_p = model_pick(req, m_ptr);
    run_cmd(100, '0, 1'b0);
    verify_cmd("to_next", exp_p, 1'b0);
    req = '0;
    idle_check("to_next_idle");

    // Reset while the controller is busy with port 2's command.
    new_addr(2);
    drive_bus();
    ack_delay = 1; busy_len = 20;
    req = 4'b0100;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ctrl_busy) break;
    end
    check("rst_op_busy_seen", 32'(ctrl_busy), 1);
    @(negedge clk);
    @(negedge clk);
    new_addr(0); new_addr(3);
    drive_bus();
    req = 4'b1101;
    rst = 1'b1;
    #1;
    check("midrst_gnt", 32'(gnt), 0);
    check("midrst_strobe", 32'(addr_strobe), 1);
    check("midrst_done", 32'(done), 0);
    check("midrst_err", 32'(err), 0);
    check("midrst_rdwr", 32'(rd_wr_req), 0);
    check("midrst_addr", 32'({sys_addr_row, sys_addr_col, sys_ba}), 0);
    m_ptr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_hold_strobe", 32'(addr_strobe), 1);
    end
    rst = 1'b0;
    exp_p = model_pick(req, m_ptr);
    run_cmd(100, '0, 1'b0);
    verify_cmd("post_rst", exp_p, 1'b0);
    check("post_rst_gnt_lat", r_gcyc, 1);
    req = '0;
    idle_check("post_rst_idle");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
